stream_demux_1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer with a valid/ready handshake on every port.
- Routes one input beat to output port A (sel_i=0) or port B (sel_i=1).
- Each output has a one-entry holding register, so one port stalling does not block the other once its beat is delivered.
- Sits downstream of a single producer and fans its traffic out to two consumers. It is the receiving-side counterpart of the 2:1 mux path.

---
 rtl/stream_demux_pkg.sv | 20 ++
 rtl/stream_demux_1to2_if.sv | 35 +++
 rtl/stream_demux_1to2_out_slot.sv | 52 +++++
 rtl/stream_demux_1to2.sv | 74 +++++++
 tb/tb_stream_demux_1to2.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_demux_pkg;

  // sel_i encoding: which output port receives the input beat
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Default widths for payload and per-port delivered-beat counters
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Output slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux_1to2_if.sv
// Handshake/payload bundle for the 1-to-2 demux: one input stream, two output streams, two counters.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every stream; slave = demux side, master = producer/consumer side.
interface stream_demux_1to2_if #(
  parameter int DATA_W = stream_demux_pkg::DEF_DATA_W,
  parameter int CNT_W  = stream_demux_pkg::DEF_CNT_W
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] data_i;
  logic              sel_i;

  logic              a_valid_o;
  logic              a_ready_i;
  logic [DATA_W-1:0] a_data_o;

  logic              b_valid_o;
  logic              b_ready_i;
  logic [DATA_W-1:0] b_data_o;

  logic [CNT_W-1:0]  a_cnt_o;
  logic [CNT_W-1:0]  b_cnt_o;

  modport slave (
    input  in_valid_i, data_i, sel_i, a_ready_i, b_ready_i,
    output in_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o, a_cnt_o, b_cnt_o
  );

  modport master (
    output in_valid_i, data_i, sel_i, a_ready_i, b_ready_i,
    input  in_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o, a_cnt_o, b_cnt_o
  );

endinterface

// File: rtl/stream_demux_1to2_out_slot.sv
// One-entry output holding register (EMPTY/FULL) for one demux port.
// Latency: 1 cycle from load to valid; drain and reload in the same cycle leave no bubble.
// Backpressure: o_can_accept = empty or being drained this cycle; data frozen while full and not ready.
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_can_accept
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              w_drain;

  assign w_drain = (r_state == SLOT_FULL) & i_ready;

  // Occupancy register; async reset discards any held beat immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SLOT_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Next occupancy: a load always leaves the slot full, a drain alone empties it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load)              w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (w_drain && !i_load)  w_state_nxt = SLOT_EMPTY;
      default:                             w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Payload register; only written on load so it holds steady under back-pressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  assign o_valid      = (r_state == SLOT_FULL);
  assign o_data       = r_data;
  assign o_can_accept = (r_state == SLOT_EMPTY) | i_ready;

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: sel_i routes each input beat to port A (0) or B (1). Optional macro DEMUX_CNT_EN.
// Latency: 1 cycle from input acceptance to valid on the selected port.
// Backpressure: in_ready_o follows only the selected port's slot; a stalled other port never blocks it.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                clk,
  input logic                reset_n,
  stream_demux_1to2_if.slave bus
);

  logic w_sel_b;
  logic w_a_can;
  logic w_b_can;
  logic w_in_ready;
  logic w_a_load;
  logic w_b_load;

  assign w_sel_b    = (bus.sel_i == SEL_B);
  // Ready is held low during reset so nothing is accepted across the reset release edge
  assign w_in_ready = reset_n & (w_sel_b ? w_b_can : w_a_can);
  assign w_a_load   = bus.in_valid_i & w_in_ready & ~w_sel_b;
  assign w_b_load   = bus.in_valid_i & w_in_ready &  w_sel_b;

  assign bus.in_ready_o = w_in_ready;

  demux_out_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_a_load),
    .i_data       (bus.data_i),
    .i_ready      (bus.a_ready_i),
    .o_valid      (bus.a_valid_o),
    .o_data       (bus.a_data_o),
    .o_can_accept (w_a_can)
  );

  demux_out_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_b_load),
    .i_data       (bus.data_i),
    .i_ready      (bus.b_ready_i),
    .o_valid      (bus.b_valid_o),
    .o_data       (bus.b_data_o),
    .o_can_accept (w_b_can)
  );

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;

  // Delivered-beat counters, one per port; free-running wrap, no saturation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (bus.a_valid_o & bus.a_ready_i) r_a_cnt <= r_a_cnt + CNT_W'(1);
      if (bus.b_valid_o & bus.b_ready_i) r_b_cnt <= r_b_cnt + CNT_W'(1);
    end
  end

  assign bus.a_cnt_o = r_a_cnt;
  assign bus.b_cnt_o = r_b_cnt;
`else
  assign bus.a_cnt_o = '0;
  assign bus.b_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Testbench for stream_demux_1to2: directed beats, per-port scoreboard queues, DEMUX_CNT_EN-aware counter checks.
// Latency: checks 1-cycle delivery and no-bubble reload.
// Backpressure: exercises stalled ports, independence of ports and mid-operation reset.
module tb_stream_demux_1to2;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stream_demux_1to2_if #(.DATA_W(8), .CNT_W(16)) bus ();
  stream_demux_1to2_if #(.DATA_W(8), .CNT_W(4))  bus_w ();

  stream_demux_1to2 #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // Narrow-counter instance used for the wrap check
  stream_demux_1to2 #(.DATA_W(8), .CNT_W(4)) u_dut_w (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_w)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one beat and wait (bounded) for acceptance; expected data goes to the port's queue
  task automatic send(input logic [7:0] d, input logic s);
    int t;
    t = 0;
    bus.in_valid_i = 1'b1;
    bus.data_i     = d;
    bus.sel_i      = s;
    #1;
    while (!bus.in_ready_o && t < 50) begin
      tick();
      t++;
    end
    check("send_accept", 32'(bus.in_ready_o), 32'd1);
    if (bus.in_ready_o) begin
      if (s == SEL_A) q_a.push_back(d);
      else            q_b.push_back(d);
    end
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  // Monitor: a beat is delivered at the next edge whenever valid & ready are both high
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_valid_o && bus.a_ready_i) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_a: got unexpected beat %0h, expected none", bus.a_data_o);
        end else begin
          check("sb_a", 32'(bus.a_data_o), 32'(q_a.pop_front()));
        end
      end
      if (bus.b_valid_o && bus.b_ready_i) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_b: got unexpected beat %0h, expected none", bus.b_data_o);
        end else begin
          check("sb_b", 32'(bus.b_data_o), 32'(q_b.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [15:0] c0;
    int n_acc;

    rst_n = 1'b1;
    bus.in_valid_i = 1'b1; bus.data_i = 8'hAA; bus.sel_i = SEL_A;
    bus.a_ready_i = 1'b1;  bus.b_ready_i = 1'b1;
    bus_w.in_valid_i = 1'b0; bus_w.data_i = 8'h00; bus_w.sel_i = SEL_A;
    bus_w.a_ready_i = 1'b1;  bus_w.b_ready_i = 1'b1;

    // Reset state with a valid beat presented
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_a_valid",  32'(bus.a_valid_o),  32'd0);
    check("rst_b_valid",  32'(bus.b_valid_o),  32'd0);
    check("rst_a_data",   32'(bus.a_data_o),   32'd0);
    check("rst_b_data",   32'(bus.b_data_o),   32'd0);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("rst_a_cnt",    32'(bus.a_cnt_o),    32'd0);
    bus.in_valid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(bus.in_ready_o), 32'd1);

    // Route A, then route B
    send(8'h05, SEL_A);
    check("rtA_a_valid", 32'(bus.a_valid_o), 32'd1);
    check("rtA_a_data",  32'(bus.a_data_o),  32'h05);
    check("rtA_b_valid", 32'(bus.b_valid_o), 32'd0);
    send(8'h10, SEL_B);
    check("rtB_b_valid", 32'(bus.b_valid_o), 32'd1);
    check("rtB_b_data",  32'(bus.b_data_o),  32'h10);
    check("rtB_a_valid", 32'(bus.a_valid_o), 32'd0);
    tick();

    // Back-pressure on A, then release with no bubble
    bus.a_ready_i = 1'b0;
    send(8'h02, SEL_A);
    bus.in_valid_i = 1'b1; bus.data_i = 8'h04; bus.sel_i = SEL_A;
    #1;
    check("bp_in_ready0", 32'(bus.in_ready_o), 32'd0);
    tick();
    check("bp_hold_data", 32'(bus.a_data_o),   32'h02);
    check("bp_in_ready1", 32'(bus.in_ready_o), 32'd0);
    bus.a_ready_i = 1'b1;
    #1;
    check("bp_in_ready2", 32'(bus.in_ready_o), 32'd1);
    q_a.push_back(8'h04);
    tick();
    bus.in_valid_i = 1'b0;
    check("bp_nobubble_valid", 32'(bus.a_valid_o), 32'd1);
    check("bp_nobubble_data",  32'(bus.a_data_o),  32'h04);
    tick();
    check("bp_drained", 32'(bus.a_valid_o), 32'd0);

    // Independence: A stalled and full must not block B
    bus.a_ready_i = 1'b0;
    send(8'h11, SEL_A);
    bus.in_valid_i = 1'b1; bus.data_i = 8'h22; bus.sel_i = SEL_B;
    #1;
    check("ind_in_ready", 32'(bus.in_ready_o), 32'd1);
    q_b.push_back(8'h22);
    tick();
    bus.in_valid_i = 1'b0;
    check("ind_b_valid", 32'(bus.b_valid_o), 32'd1);
    check("ind_b_data",  32'(bus.b_data_o),  32'h22);
    check("ind_a_valid", 32'(bus.a_valid_o), 32'd1);
    check("ind_a_data",  32'(bus.a_data_o),  32'h11);
    bus.a_ready_i = 1'b1;
    tick();
    tick();

    // Throughput: 256 random beats, both consumers always ready
    c0 = bus.a_cnt_o + bus.b_cnt_o;
    n_acc = 0;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid_i = 1'b1;
      bus.data_i     = 8'($urandom);
      bus.sel_i      = 1'($urandom);
      #1;
      if (bus.in_ready_o) begin
        n_acc++;
        if (bus.sel_i == SEL_A) q_a.push_back(bus.data_i);
        else                    q_b.push_back(bus.data_i);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    check("tp_accepts", 32'(n_acc), 32'd256);
    check("tp_q_a_left", 32'(q_a.size()), 32'd0);
    check("tp_q_b_left", 32'(q_b.size()), 32'd0);
`ifdef DEMUX_CNT_EN
    check("tp_cnt_sum", 32'(16'(bus.a_cnt_o + bus.b_cnt_o - c0)), 32'd256);
`else
    check("tp_cnt_a_tied", 32'(bus.a_cnt_o), 32'd0);
    check("tp_cnt_b_tied", 32'(bus.b_cnt_o), 32'd0);
`endif

    // Reset mid-operation with both slots full
    bus.a_ready_i = 1'b0;
    bus.b_ready_i = 1'b0;
    send(8'h33, SEL_A);
    send(8'h44, SEL_B);
    check("mid_a_full", 32'(bus.a_valid_o), 32'd1);
    check("mid_b_full", 32'(bus.b_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_a_drop", 32'(bus.a_valid_o), 32'd0);
    check("mid_b_drop", 32'(bus.b_valid_o), 32'd0);
    check("mid_cnt_clr", 32'(bus.a_cnt_o), 32'd0);
    q_a.delete();
    q_b.delete();
    bus.a_ready_i = 1'b1;
    bus.b_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Counter wrap on the 4-bit instance: 17 A beats
    for (int i = 0; i < 17; i++) begin
      bus_w.in_valid_i = 1'b1;
      bus_w.data_i     = 8'(i);
      bus_w.sel_i      = SEL_A;
      tick();
    end
    bus_w.in_valid_i = 1'b0;
    tick();
    tick();
`ifdef DEMUX_CNT_EN
    check("wrap_a_cnt", 32'(bus_w.a_cnt_o), 32'd1);
`else
    check("wrap_a_cnt", 32'(bus_w.a_cnt_o), 32'd0);
`endif
    check("wrap_b_cnt", 32'(bus_w.b_cnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
